// File: rtl/tl_ul_pkg.sv
// Shared definitions for the TileLink-UL SRAM responder: channel opcodes,
// FSM state encoding and the size-to-beat-count helper.
package tl_ul_pkg;

  localparam logic [2:0] A_PUT_FULL        = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] A_GET             = 3'd4;
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

  // Wide enough to count the beats of the largest encodable size (2^7 / 4 = 32).
  localparam int BEAT_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_RESP,
    ST_WR,
    ST_ACK
  } state_e;

  // Number of 32-bit beats carried by a message of 2^size bytes.
  function automatic logic [BEAT_W-1:0] beats_from_size(input logic [2:0] size);
    if (size <= 3'd2) return BEAT_W'(1);
    return BEAT_W'(1) << (size - 3'd2);
  endfunction

endpackage

// File: rtl/tl_ul_sram_responder_if.sv
// TileLink-UL A and D channel bundle between a master and this responder.
interface tl_ul_sram_responder_if #(
  parameter int SRC_W  = 3,
  parameter int ADDR_W = 15
);

  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [2:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [3:0]        a_mask;
  logic [31:0]       a_data;
  logic              a_corrupt;

  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [2:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_sink;
  logic              d_denied;
  logic [31:0]       d_data;
  logic              d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    input  d_ready
  );

endinterface

// File: rtl/tl_ul_req_check.sv
// Combinational legality decode of the first A beat: unsupported opcode,
// oversize, misaligned or out-of-range requests are denied.
module tl_ul_req_check
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int MAX_SIZE    = 3,
  parameter int DEPTH_BYTES = 32768
) (
  input  logic [2:0]        opcode,
  input  logic [2:0]        size,
  input  logic [ADDR_W-1:0] address,
  output logic              denied
);

  logic [31:0] span;
  logic [31:0] addr_ext;
  logic        bad_op;
  logic        bad_size;
  logic        misaligned;
  logic        overrun;

  // Evaluate each deny reason in 32-bit arithmetic so address+span cannot wrap.
  always_comb begin
    span       = 32'd1 << size;
    addr_ext   = 32'(address);
    bad_op     = !(opcode inside {A_PUT_FULL, A_PUT_PARTIAL, A_GET});
    bad_size   = 32'(size) > 32'(MAX_SIZE);
    misaligned = (addr_ext & (span - 32'd1)) != 32'd0;
    overrun    = (addr_ext + span) > 32'(DEPTH_BYTES);
    denied     = bad_op | bad_size | misaligned | overrun;
  end

endmodule

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL manager terminating Get/PutFullData/PutPartialData into a
// single-port synchronous word memory. Optional denied-request counter is
// built when TLRSP_DENY_CNT_EN is defined (ports deny_cnt / deny_cnt_clr).
module tl_ul_sram_responder
  import tl_ul_pkg::*;
#(
  parameter int SRC_W       = 3,
  parameter int ADDR_W      = 15,
  parameter int MAX_SIZE    = 3,
  parameter int DEPTH_BYTES = 32768
) (
  input  logic                clock,
  input  logic                reset,
`ifdef TLRSP_DENY_CNT_EN
  output logic [15:0]         deny_cnt,
  input  logic                deny_cnt_clr,
`endif
  tl_ul_sram_responder_if.slave tl,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [3:0]          mem_wmask,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  localparam int WADDR_W = ADDR_W - 2;

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beats_q, beats_d;     // beats still to return (Get) or accept (Put)
  logic [WADDR_W-1:0] addr_q, addr_d;       // word address of the last issued access
  logic [SRC_W-1:0]   source_q, source_d;
  logic [2:0]         size_q, size_d;
  logic               denied_q, denied_d;
  logic [31:0]        data_q, data_d;

  logic               req_denied;
  logic               accept_ok;
  logic               resp_valid;
  logic               a_fire;
  logic               d_fire;
  logic               a_is_get;
  logic [BEAT_W-1:0]  req_beats;
  logic [WADDR_W-1:0] req_waddr;
  logic [WADDR_W-1:0] next_waddr;
  logic               unused_ok;

  tl_ul_req_check #(
    .ADDR_W      (ADDR_W),
    .MAX_SIZE    (MAX_SIZE),
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_req_check (
    .opcode  (tl.a_opcode),
    .size    (tl.a_size),
    .address (tl.a_address),
    .denied  (req_denied)
  );

  // A is only open while idle or collecting Put beats, and never during reset.
  assign accept_ok  = !reset && (state_q == ST_IDLE || state_q == ST_WR);
  assign resp_valid = (state_q == ST_RD_RESP) || (state_q == ST_ACK);
  assign a_fire     = tl.a_valid & accept_ok;
  assign d_fire     = resp_valid & tl.d_ready;
  assign a_is_get   = tl.a_opcode == A_GET;
  assign req_beats  = beats_from_size(tl.a_size);
  assign req_waddr  = tl.a_address[ADDR_W-1:2];
  assign next_waddr = addr_q + WADDR_W'(1);
  assign unused_ok  = ^tl.a_param;

  // State and captured request context.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q  <= ST_IDLE;
      beats_q  <= '0;
      addr_q   <= '0;
      source_q <= '0;
      size_q   <= '0;
      denied_q <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      beats_q  <= beats_d;
      addr_q   <= addr_d;
      source_q <= source_d;
      size_q   <= size_d;
      denied_q <= denied_d;
      data_q   <= data_d;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: each variable gets a default before the case so no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (a_fire) begin
          if (a_is_get) state_d = req_denied ? ST_RD_RESP : ST_RD_WAIT;
          else          state_d = (req_beats == BEAT_W'(1)) ? ST_ACK : ST_WR;
        end
      end
      ST_RD_WAIT: state_d = ST_RD_RESP;
      ST_RD_RESP: begin
        // Denied Gets skip the memory round trip and emit beats back to back.
        if (d_fire) begin
          if (beats_q == BEAT_W'(1)) state_d = ST_IDLE;
          else                       state_d = denied_q ? ST_RD_RESP : ST_RD_WAIT;
        end
      end
      ST_WR:   if (a_fire && beats_q == BEAT_W'(1)) state_d = ST_ACK;
      ST_ACK:  if (d_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Context capture, beat counting and read-data capture.
  always_comb begin
    beats_d  = beats_q;
    addr_d   = addr_q;
    source_d = source_q;
    size_d   = size_q;
    denied_d = denied_q;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (a_fire) begin
          source_d = tl.a_source;
          size_d   = tl.a_size;
          denied_d = req_denied;
          addr_d   = req_waddr;
          data_d   = '0;
          beats_d  = a_is_get ? req_beats : req_beats - BEAT_W'(1);
        end
      end
      ST_RD_WAIT: data_d = mem_rdata;
      ST_RD_RESP: begin
        if (d_fire) begin
          beats_d = beats_q - BEAT_W'(1);
          addr_d  = next_waddr;
        end
      end
      ST_WR: begin
        if (a_fire) begin
          beats_d = beats_q - BEAT_W'(1);
          addr_d  = next_waddr;
        end
      end
      default: ;
    endcase
  end

  // Memory port: first access straight from the A beat, later ones from addr_q+1.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wmask = '0;
    mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (a_fire && !req_denied) begin
          mem_addr = req_waddr;
          if (a_is_get) begin
            mem_req = 1'b1;
          end else if (!tl.a_corrupt) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_wmask = tl.a_mask;
            mem_wdata = tl.a_data;
          end
        end
      end
      ST_WR: begin
        if (a_fire && !denied_q && !tl.a_corrupt) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = next_waddr;
          mem_wmask = tl.a_mask;
          mem_wdata = tl.a_data;
        end
      end
      ST_RD_RESP: begin
        if (d_fire && !denied_q && beats_q != BEAT_W'(1)) begin
          mem_req  = 1'b1;
          mem_addr = next_waddr;
        end
      end
      default: ;
    endcase
  end

  // Channel outputs, all sourced from registered state.
  always_comb begin
    tl.a_ready   = accept_ok;
    tl.d_valid   = resp_valid;
    tl.d_opcode  = (state_q == ST_RD_RESP) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
    tl.d_param   = 2'd0;
    tl.d_size    = size_q;
    tl.d_source  = source_q;
    tl.d_sink    = 1'b0;
    tl.d_denied  = denied_q;
    tl.d_data    = data_q;
    tl.d_corrupt = denied_q;
  end

`ifdef TLRSP_DENY_CNT_EN
  logic [15:0] deny_cnt_q, deny_cnt_d;
  logic        last_d_fire;

  assign last_d_fire = d_fire & ((state_q == ST_ACK) | (beats_q == BEAT_W'(1)));
  assign deny_cnt    = deny_cnt_q;

  // Saturating count of denied requests; clear wins over a same-cycle increment.
  always_comb begin
    deny_cnt_d = deny_cnt_q;
    if (deny_cnt_clr)                                          deny_cnt_d = '0;
    else if (last_d_fire && denied_q && deny_cnt_q != 16'hFFFF) deny_cnt_d = deny_cnt_q + 16'd1;
  end

  // Deny counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) deny_cnt_q <= '0;
    else       deny_cnt_q <= deny_cnt_d;
  end
`endif

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Directed self-checking bench for tl_ul_sram_responder with a behavioural
// synchronous SRAM. Inputs change 1ns after posedge; outputs sampled at negedge.
module tb_tl_ul_sram_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req, mem_we;
  logic [12:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
`ifdef TLRSP_DENY_CNT_EN
  logic [15:0] deny_cnt;
  logic        deny_cnt_clr = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int mem_req_cnt = 0;

  logic        acc_req, acc_we;
  logic [12:0] acc_addr;
  logic [3:0]  acc_wmask;
  logic [31:0] acc_wdata;

  logic [31:0] sram [0:8191];

  tl_ul_sram_responder_if #(.SRC_W(3), .ADDR_W(15)) tl ();

  tl_ul_sram_responder #(
    .SRC_W(3), .ADDR_W(15), .MAX_SIZE(3), .DEPTH_BYTES(32768)
  ) dut (
    .clock        (clock),
    .reset        (reset),
`ifdef TLRSP_DENY_CNT_EN
    .deny_cnt     (deny_cnt),
    .deny_cnt_clr (deny_cnt_clr),
`endif
    .tl           (tl.slave),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wmask    (mem_wmask),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural single-port SRAM: byte-masked writes, read data one cycle later.
  always @(posedge clock) begin
    if (mem_req) begin
      mem_req_cnt <= mem_req_cnt + 1;
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one A beat and hold it until accepted; snapshot the memory port in the accept cycle.
  task automatic send_a(input logic [2:0] op, input logic [2:0] size, input logic [2:0] src,
                        input logic [14:0] addr, input logic [3:0] mask, input logic [31:0] data,
                        input logic corrupt);
    bit done = 0;
    tl.a_valid = 1'b1; tl.a_opcode = op; tl.a_size = size; tl.a_source = src;
    tl.a_address = addr; tl.a_mask = mask; tl.a_data = data; tl.a_corrupt = corrupt;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      if (tl.a_ready) begin
        done = 1;
        acc_req = mem_req; acc_we = mem_we; acc_addr = mem_addr;
        acc_wmask = mem_wmask; acc_wdata = mem_wdata;
      end
      @(posedge clock); #1;
    end
    if (!done) check("a_accept_timeout", {31'd0, tl.a_ready}, 32'd1);
    tl.a_valid = 1'b0; tl.a_corrupt = 1'b0;
  endtask

  // Wait for one D beat (d_ready assumed high); lat counts negedges until it was seen.
  task automatic get_d(output int lat, output logic [31:0] data, output logic [2:0] op,
                       output logic den, output logic cor, output logic [2:0] src);
    bit done = 0;
    lat = 0; data = '0; op = '0; den = 1'b0; cor = 1'b0; src = '0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      lat++;
      if (tl.d_valid && tl.d_ready) begin
        done = 1;
        data = tl.d_data; op = tl.d_opcode; den = tl.d_denied; cor = tl.d_corrupt; src = tl.d_source;
      end
      @(posedge clock); #1;
    end
    if (!done) check("d_timeout", {31'd0, tl.d_valid}, 32'd1);
  endtask

  // Consume a denied read response, checking each beat, and return the beat count.
  task automatic drain_denied(input string tag, output int n);
    int idle = 0;
    n = 0;
    for (int i = 0; i < 40 && idle < 4; i++) begin
      @(negedge clock);
      if (tl.d_valid && tl.d_ready) begin
        n++; idle = 0;
        check({tag, "_denied"},  {31'd0, tl.d_denied},  32'd1);
        check({tag, "_corrupt"}, {31'd0, tl.d_corrupt}, 32'd1);
        check({tag, "_data"},    tl.d_data,             32'd0);
      end else begin
        idle++;
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int          lat, n, snap, stale;
    logic [31:0] data;
    logic [2:0]  op, src;
    logic        den, cor;

    for (int i = 0; i < 8192; i++) sram[i] = '0;
    sram[4] = 32'hDEADBEEF;

    reset = 1'b1;
    tl.a_valid = 1'b0; tl.a_opcode = '0; tl.a_param = '0; tl.a_size = '0; tl.a_source = '0;
    tl.a_address = '0; tl.a_mask = '0; tl.a_data = '0; tl.a_corrupt = 1'b0; tl.d_ready = 1'b1;

    // Reset state
    @(negedge clock);
    check("rst_a_ready", {31'd0, tl.a_ready}, 32'd0);
    check("rst_d_valid", {31'd0, tl.d_valid}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req},    32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_a_ready", {31'd0, tl.a_ready}, 32'd1);
    check("post_rst_d_data",  tl.d_data,           32'd0);
    check("post_rst_d_src",   {29'd0, tl.d_source}, 32'd0);
    @(posedge clock); #1;

    // Single-beat Get of word 4
    send_a(3'd4, 3'd2, 3'd5, 15'h0010, 4'hF, 32'd0, 1'b0);
    check("get_mem_req",  {31'd0, acc_req}, 32'd1);
    check("get_mem_we",   {31'd0, acc_we},  32'd0);
    check("get_mem_addr", {19'd0, acc_addr}, 32'd4);
    get_d(lat, data, op, den, cor, src);
    check("get_latency", lat, 32'd2);
    check("get_opcode",  {29'd0, op},  32'd1);
    check("get_source",  {29'd0, src}, 32'd5);
    check("get_data",    data,         32'hDEADBEEF);
    check("get_denied",  {31'd0, den}, 32'd0);
    check("get_corrupt", {31'd0, cor}, 32'd0);

    // PutPartial with a two-lane mask, then read it back
    send_a(3'd1, 3'd2, 3'd3, 15'h0020, 4'h6, 32'h11223344, 1'b0);
    check("pp_mem_we",    {31'd0, acc_we},  32'd1);
    check("pp_mem_addr",  {19'd0, acc_addr}, 32'd8);
    check("pp_mem_wmask", {28'd0, acc_wmask}, 32'h6);
    check("pp_mem_wdata", acc_wdata, 32'h11223344);
    get_d(lat, data, op, den, cor, src);
    check("pp_ack_latency", lat, 32'd1);
    check("pp_ack_opcode",  {29'd0, op},  32'd0);
    check("pp_ack_source",  {29'd0, src}, 32'd3);
    send_a(3'd4, 3'd2, 3'd1, 15'h0020, 4'hF, 32'd0, 1'b0);
    get_d(lat, data, op, den, cor, src);
    check("pp_readback", data, 32'h00223300);

    // Two-beat PutFull to words 16/17
    send_a(3'd0, 3'd3, 3'd2, 15'h0040, 4'hF, 32'hA0A0A0A0, 1'b0);
    check("burst_w0_addr", {19'd0, acc_addr}, 32'd16);
    check("burst_w0_we",   {31'd0, acc_we},   32'd1);
    send_a(3'd0, 3'd3, 3'd2, 15'h0040, 4'hF, 32'hB1B1B1B1, 1'b0);
    check("burst_w1_addr", {19'd0, acc_addr}, 32'd17);
    check("burst_w1_data", acc_wdata, 32'hB1B1B1B1);
    get_d(lat, data, op, den, cor, src);
    check("burst_ack_opcode", {29'd0, op}, 32'd0);

    // Two-beat Get with beat 0 stalled for 4 cycles
    tl.d_ready = 1'b0;
    send_a(3'd4, 3'd3, 3'd6, 15'h0040, 4'hF, 32'd0, 1'b0);
    for (int i = 0; i < 10 && !tl.d_valid; i++) @(negedge clock);
    check("stall_valid", {31'd0, tl.d_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("stall_hold_valid", {31'd0, tl.d_valid}, 32'd1);
      check("stall_hold_data",  tl.d_data, 32'hA0A0A0A0);
    end
    @(posedge clock); #1;
    tl.d_ready = 1'b1;
    get_d(lat, data, op, den, cor, src);
    check("rd_burst_b0", data, 32'hA0A0A0A0);
    get_d(lat, data, op, den, cor, src);
    check("rd_burst_b1",     data, 32'hB1B1B1B1);
    check("rd_burst_b1_lat", lat,  32'd2);
    check("rd_burst_src",    {29'd0, src}, 32'd6);
    drain_denied("rd_burst_extra", n);
    check("rd_burst_no_extra", n, 32'd0);

    // Poisoned Put beat is dropped but still acknowledged
    send_a(3'd0, 3'd2, 3'd1, 15'h0030, 4'hF, 32'hFFFFFFFF, 1'b1);
    check("corrupt_no_write", {31'd0, acc_req}, 32'd0);
    get_d(lat, data, op, den, cor, src);
    check("corrupt_ack_denied", {31'd0, den}, 32'd0);
    send_a(3'd4, 3'd2, 3'd1, 15'h0030, 4'hF, 32'd0, 1'b0);
    get_d(lat, data, op, den, cor, src);
    check("corrupt_readback", data, 32'd0);

    // Denied Gets: misaligned (1 beat) and overrun (2 beats), no memory traffic
    snap = mem_req_cnt;
    send_a(3'd4, 3'd2, 3'd4, 15'h0002, 4'hF, 32'd0, 1'b0);
    drain_denied("misalign", n);
    check("misalign_beats", n, 32'd1);
    send_a(3'd4, 3'd3, 3'd4, 15'h7FFC, 4'hF, 32'd0, 1'b0);
    drain_denied("overrun", n);
    check("overrun_beats", n, 32'd2);

    // Denied two-beat Put: both beats consumed, one denied ack
    send_a(3'd0, 3'd3, 3'd7, 15'h0004, 4'hF, 32'h12345678, 1'b0);
    send_a(3'd0, 3'd3, 3'd7, 15'h0004, 4'hF, 32'h9ABCDEF0, 1'b0);
    get_d(lat, data, op, den, cor, src);
    check("deny_put_opcode", {29'd0, op},  32'd0);
    check("deny_put_denied", {31'd0, den}, 32'd1);
    check("deny_put_source", {29'd0, src}, 32'd7);
    check("deny_no_mem_req", mem_req_cnt - snap, 32'd0);

`ifdef TLRSP_DENY_CNT_EN
    deny_cnt_clr = 1'b1;
    @(posedge clock); #1;
    deny_cnt_clr = 1'b0;
    @(negedge clock);
    check("deny_cnt_cleared", {16'd0, deny_cnt}, 32'd0);
    @(posedge clock); #1;
`endif

    // Unsupported opcode (Arithmetic) is acknowledged as denied
    send_a(3'd2, 3'd2, 3'd2, 15'h0000, 4'hF, 32'd0, 1'b0);
    get_d(lat, data, op, den, cor, src);
    check("arith_opcode", {29'd0, op},  32'd0);
    check("arith_denied", {31'd0, den}, 32'd1);
`ifdef TLRSP_DENY_CNT_EN
    @(negedge clock);
    check("deny_cnt_step", {16'd0, deny_cnt}, 32'd1);
    @(posedge clock); #1;
    deny_cnt_clr = 1'b1;
    send_a(3'd2, 3'd2, 3'd2, 15'h0000, 4'hF, 32'd0, 1'b0);
    get_d(lat, data, op, den, cor, src);
    deny_cnt_clr = 1'b0;
    @(negedge clock);
    check("deny_cnt_clr_wins", {16'd0, deny_cnt}, 32'd0);
    @(posedge clock); #1;
`endif

    // Reset while waiting for read data aborts the Get
    send_a(3'd4, 3'd2, 3'd1, 15'h0010, 4'hF, 32'd0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_d_valid", {31'd0, tl.d_valid}, 32'd0);
    check("midrst_a_ready", {31'd0, tl.a_ready}, 32'd0);
    check("midrst_mem_req", {31'd0, mem_req},    32'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("midrst_release_a_ready", {31'd0, tl.a_ready}, 32'd1);
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      if (tl.d_valid) stale++;
      @(negedge clock);
    end
    check("midrst_no_stale_d", stale, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_ul_sram_responder.md
Name: tl_ul_sram_responder

Overview:
- TileLink-UL responder (manager end) terminating the A channel driven by the width-widget/fragmenter master chain, serving accesses into a single-port synchronous SRAM-style word array.
- Accepts Get/PutFullData/PutPartialData up to 2^MAX_SIZE bytes, collects multi-beat Puts, expands multi-beat Gets and returns D-channel AccessAck/AccessAckData.
- Sits at the slave side of the local TL crossbar, in front of tightly-coupled memory or a register bank.

Parameters:
- SRC_W, 3, a_source/d_source width.
- ADDR_W, 15, byte-address width; the memory word address is ADDR_W-2 bits.
- MAX_SIZE, 3, largest accepted lg2(bytes); beats = 2^MAX_SIZE/4 when size > 2.
- DEPTH_BYTES, 32768, implemented bytes; addresses at or above this are denied.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- a_valid, a_ready  in/out  1  A handshake.
- a_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get.
- a_param  in  3  ignored.
- a_size  in  3  lg2 bytes.
- a_source  in  SRC_W  request id.
- a_address  in  ADDR_W  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- a_corrupt  in  1  write beat poisoned.
- d_valid, d_ready  out/in  1  D handshake.
- d_opcode  out  3  0=AccessAck, 1=AccessAckData.
- d_param  out  2  always 0.
- d_size  out  3  echoed a_size.
- d_source  out  SRC_W  echoed a_source.
- d_sink  out  1  always 0.
- d_denied  out  1  request refused.
- d_data  out  32  read data.
- d_corrupt  out  1  data invalid.
- mem_req  out  1  memory access this cycle.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W-2  word address.
- mem_wmask  out  4  byte write mask.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid the cycle after a read mem_req.

Behaviour:
- Reset: state=IDLE; a_ready=1 once reset deasserts; d_valid=0; all D fields, beat counter and captured context cleared to 0; mem_req=0.
- Reset asserted mid-transaction aborts it. No D beat is produced. A memory write in the same cycle is not issued.
- States:
  - IDLE: a_ready=1.
  - RD_WAIT: a_ready=0, waiting for mem_rdata.
  - RD_RESP: d_valid=1, AccessAckData beat held.
  - WR: a_ready=1, collecting Put beats.
  - ACK: d_valid=1, AccessAck.
- Error check on the first A beat: denied if opcode is not in {0,1,4}, size > MAX_SIZE, address is not aligned to 2^size, or address+2^size > DEPTH_BYTES.
- Denied requests never assert mem_req.
- Get accepted in cycle N:
  - N: mem_req=1, mem_we=0, mem_addr=addr>>2.
  - N+1: mem_rdata captured into d_data.
  - N+2: d_valid=1.
- Get, further beats: D fires in cycle M; the next read is issued in M with the word address incremented; d_valid=0 in M+1; the next beat is valid in M+2.
  - Beat count is 1 for size <= 2, else 2^size/4.
  - After the last D fire, go to IDLE.
- Denied Get: returns the full beat count from RD_RESP, each beat one cycle apart after a D fire. Each beat has d_denied=1, d_corrupt=1, d_data=0.
- Put, first beat fires in IDLE in cycle N:
  - If not denied: the write is issued in N with mem_wmask=a_mask, mem_wdata=a_data.
  - Size <= 2: go to ACK; d_valid=1 in N+1.
  - Larger sizes: go to WR and accept the remaining beats one write per fire, with address incremented.
  - The last beat goes to ACK.
- Denied Put: all beats are still consumed, then AccessAck with d_denied=1.
- A Put beat with a_corrupt=1 is not written (mem_req=0). The ack is unaffected.
- PutFull with a mask that is not all-ones is written as given. Mask checking is the monitor's job.
- D outputs are registered and held stable while d_valid & !d_ready. d_corrupt=0 for non-denied responses.
- A new A beat is never accepted in the same cycle as the D fire that completes the previous request (a_ready=0 in ACK/RD_*). The earliest next accept is the cycle after.

Optional Feature:
- Macro: TLRSP_DENY_CNT_EN.
- When defined: adds output deny_cnt (16 bits) and input deny_cnt_clr (1 bit).
  - The counter increments once per denied request on the final D fire.
  - It saturates at 0xFFFF and resets to 0.
  - deny_cnt_clr has priority over an increment in the same cycle.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package tl_ul_pkg: A/D opcode localparams, state enum typedef, beats-from-size function.
- One natural sub-module: tl_ul_req_check (combinational denied decode from opcode/size/address).

Test Plan:
- Get 0x0010, size 2, source 5; mem word 4 = 0xDEADBEEF:
  - mem_req/addr 4 in the accept cycle; d_valid two cycles later.
  - D beat: opcode 1, source 5, d_data 0xDEADBEEF, denied 0.
- PutPartial 0x0020, mask 0x6, data 0x11223344 -> mem write addr 8, wmask 0x6; AccessAck next cycle, source echoed.
- PutFull size 3 @0x0040 (2 beats), then Get size 3 with d_ready low for 4 cycles on beat 0:
  - writes to words 16 and 17.
  - D data held stable during the stall.
  - 2 beats returned in order.
- Get @0x0002 size 2 (misaligned) and Get @0x8000-4 size 3 (overrun):
  - denied=1, corrupt=1, data 0, beat counts 1 and 2.
  - no mem_req.
- Opcode 2 (Arithmetic) -> AccessAck denied=1; with TLRSP_DENY_CNT_EN, deny_cnt steps 0->1; clr together with a deny -> 0.
- Reset asserted while in RD_WAIT:
  - d_valid=0 and a_ready=0 during reset.
  - a_ready=1 the first cycle after deassertion.
  - no stale D beat.
